// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for a 32-bit combinational ALU: accepts a command, holds the ALU
// inputs for ALU_LAT cycles, captures result/flags and returns them. SHLN is built from repeated SHL1 passes.
module alu_op_sequencer #(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    output logic [31:0]      aluOperandA,
    output logic [31:0]      aluOperandB,
    output logic [3:0]       aluOpsel,
    input  logic [31:0]      aluResult,
    input  logic             aluOverflow,
    input  logic             aluEqual,
    input  logic [1:0]       aluCarry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_equal,
    output logic [1:0]       rsp_carry,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SHL1 = 4'b1001;
    localparam logic [3:0] OP_MOV  = 4'b1011;
    localparam logic [3:0] OP_SHLN = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LOOP  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        opA_q, opA_d;
    logic [31:0]        opB_q, opB_d;
    logic [4:0]         shCnt_q, shCnt_d;
    logic [LAT_W-1:0]   latCnt_q, latCnt_d;
    logic [31:0]        rspResult_q, rspResult_d;
    logic               rspOverflow_q, rspOverflow_d;
    logic               rspEqual_q, rspEqual_d;
    logic [1:0]         rspCarry_q, rspCarry_d;
    logic               rspErr_q, rspErr_d;
    logic [CNT_W-1:0]   opCount_q, opCount_d;
    logic               latLast;

    function automatic logic isAluOp(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SHL1, OP_MOV: isAluOp = 1'b1;
            default: isAluOp = 1'b0;
        endcase
    endfunction

    assign latLast = (latCnt_q == LAT_LAST);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        opA_d         = opA_q;
        opB_d         = opB_q;
        shCnt_d       = shCnt_q;
        latCnt_d      = latCnt_q;
        rspResult_d   = rspResult_q;
        rspOverflow_d = rspOverflow_q;
        rspEqual_d    = rspEqual_q;
        rspCarry_d    = rspCarry_q;
        rspErr_d      = rspErr_q;
        opCount_d     = opCount_q;

        case (state_q)
            IDLE: begin
                latCnt_d = '0;
                if (cmd_valid && cmd_ready) begin
                    op_d  = cmd_op;
                    opA_d = cmd_a;
                    opB_d = cmd_b;
                    if (isAluOp(cmd_op)) begin
                        state_d = ISSUE;
                    end else if (cmd_op == OP_SHLN) begin
                        shCnt_d = cmd_b[4:0];
                        state_d = LOOP;
                    end else begin
                        rspResult_d   = '0;
                        rspOverflow_d = 1'b0;
                        rspEqual_d    = 1'b0;
                        rspCarry_d    = 2'b00;
                        rspErr_d      = (cmd_op != OP_NOP);
                        state_d       = RESP;
                    end
                end
            end

            ISSUE: begin
                if (latLast) begin
                    rspResult_d   = aluResult;
                    rspOverflow_d = aluOverflow;
                    rspEqual_d    = aluEqual;
                    rspCarry_d    = aluCarry;
                    rspErr_d      = 1'b0;
                    latCnt_d      = '0;
                    state_d       = RESP;
                end else begin
                    latCnt_d = latCnt_q + LAT_W'(1);
                end
            end

            // A zero count gets one MOV pass so the response still carries operand A.
            LOOP: begin
                if (latLast) begin
                    rspResult_d   = aluResult;
                    rspOverflow_d = 1'b0;
                    rspEqual_d    = 1'b0;
                    rspCarry_d    = 2'b00;
                    rspErr_d      = 1'b0;
                    latCnt_d      = '0;
                    if (shCnt_q != 5'd0) begin
                        opA_d   = aluResult;
                        shCnt_d = shCnt_q - 5'd1;
                    end
                    if (shCnt_q <= 5'd1) begin
                        state_d = RESP;
                    end
                end else begin
                    latCnt_d = latCnt_q + LAT_W'(1);
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    if (opCount_q != {CNT_W{1'b1}}) begin
                        opCount_d = opCount_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= OP_NOP;
            opA_q         <= '0;
            opB_q         <= '0;
            shCnt_q       <= '0;
            latCnt_q      <= '0;
            rspResult_q   <= '0;
            rspOverflow_q <= 1'b0;
            rspEqual_q    <= 1'b0;
            rspCarry_q    <= 2'b00;
            rspErr_q      <= 1'b0;
            opCount_q     <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            opA_q         <= opA_d;
            opB_q         <= opB_d;
            shCnt_q       <= shCnt_d;
            latCnt_q      <= latCnt_d;
            rspResult_q   <= rspResult_d;
            rspOverflow_q <= rspOverflow_d;
            rspEqual_q    <= rspEqual_d;
            rspCarry_q    <= rspCarry_d;
            rspErr_q      <= rspErr_d;
            opCount_q     <= opCount_d;
        end
    end

    // The ALU sees a quiet NOP with zero operands outside of the issue/loop states.
    always_comb begin
        aluOperandA = '0;
        aluOperandB = '0;
        aluOpsel    = OP_NOP;
        case (state_q)
            ISSUE: begin
                aluOperandA = opA_q;
                aluOperandB = opB_q;
                aluOpsel    = op_q;
            end
            LOOP: begin
                aluOperandA = opA_q;
                aluOperandB = opB_q;
                aluOpsel    = (shCnt_q == 5'd0) ? OP_MOV : OP_SHL1;
            end
            default: ;
        endcase
    end

    // cmd_ready is gated by rst_n so every output reads zero while reset is held.
    assign cmd_ready    = rst_n && (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_result   = rspResult_q;
    assign rsp_overflow = rspOverflow_q;
    assign rsp_equal    = rspEqual_q;
    assign rsp_carry    = rspCarry_q;
    assign rsp_err      = rspErr_q;
    assign op_count     = opCount_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 32-bit ALU attached to the ALU ports.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [31:0] aluOperandA;
    logic [31:0] aluOperandB;
    logic [3:0]  aluOpsel;
    logic [31:0] aluResult;
    logic        aluOverflow;
    logic        aluEqual;
    logic [1:0]  aluCarry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_overflow;
    logic        rsp_equal;
    logic [1:0]  rsp_carry;
    logic        rsp_err;
    logic        busy;
    logic [15:0] op_count;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        eq;
        logic [1:0]  carry;
        logic        err;
        int          lat;
        int          shl;
        int          mov;
    } vec_t;

    vec_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   expCount = 0;
    int   shl1Cycles = 0;
    int   movCycles = 0;
    int   opselNonZero = 0;

    alu_op_sequencer #(.ALU_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .aluOperandA(aluOperandA), .aluOperandB(aluOperandB), .aluOpsel(aluOpsel),
        .aluResult(aluResult), .aluOverflow(aluOverflow), .aluEqual(aluEqual), .aluCarry(aluCarry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_equal(rsp_equal), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: SUB returns magnitude with borrow in carry[0]; equal compares the operands.
    function automatic logic [35:0] aluModel(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        ov;
        logic [1:0]  c;
        r  = '0;
        ov = 1'b0;
        c  = 2'b00;
        s  = '0;
        case (sel)
            4'b0001: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                c  = {1'b0, s[32]};
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0010: begin
                r = (a >= b) ? (a - b) : (b - a);
                c = {1'b0, (a < b)};
            end
            4'b0101: r = a & b;
            4'b0110: r = a | b;
            4'b0111: r = ~a;
            4'b1000: r = a ^ b;
            4'b1001: begin
                r = {a[30:0], 1'b0};
                c = {1'b0, a[31]};
            end
            4'b1011: r = a;
            default: r = '0;
        endcase
        return {r, ov, (a == b), c};
    endfunction

    always_comb {aluResult, aluOverflow, aluEqual, aluCarry} = aluModel(aluOpsel, aluOperandA, aluOperandB);

    // Counts ALU passes per opcode so the loop structure of SHLN can be verified.
    always @(posedge clk) begin
        if (aluOpsel == 4'b1001) shl1Cycles++;
        if (aluOpsel == 4'b1011) movCycles++;
        if (aluOpsel != 4'b0000) opselNonZero++;
    end

    function automatic vec_t mkVec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] res, input logic ovf, input logic eq,
                                   input logic [1:0] carry, input logic err, input int lat,
                                   input int shl, input int mov);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.ovf = ovf; v.eq = eq;
        v.carry = carry; v.err = err; v.lat = lat; v.shl = shl; v.mov = mov;
        return v;
    endfunction

    // Presents a command from a falling edge and holds it until the rising edge that accepts it.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output bit accepted);
        int guard;
        guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        #1;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        accepted = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Latency counts the acceptance edge as cycle 1; gives up after 100 cycles.
    task automatic waitResponse(output int lat);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic completeHandshake();
        if (rsp_valid) expCount++;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, busy, aluOpsel, aluOperandA, aluOperandB, rsp_result,
             rsp_overflow, rsp_equal, rsp_carry, rsp_err, op_count} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: cmd_ready=%b rsp_valid=%b busy=%b opsel=%h count=%0d required all zero",
                     cmd_ready, rsp_valid, busy, aluOpsel, op_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_alu_ops();
        vec_t tbl[$];
        vec_t e;
        int   lat;
        bit   acc;
        tbl.push_back(mkVec(4'b0001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 2'b01, 1'b0, 2, 0, 0));
        tbl.push_back(mkVec(4'b0010, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 2'b00, 1'b0, 2, 0, 0));
        tbl.push_back(mkVec(4'b0010, 32'h00000003, 32'h00000005, 32'h00000002, 1'b0, 1'b0, 2'b01, 1'b0, 2, 0, 0));
        tbl.push_back(mkVec(4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 2'b00, 1'b0, 2, 0, 0));
        tbl.push_back(mkVec(4'b0110, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 2'b00, 1'b0, 2, 0, 0));
        tbl.push_back(mkVec(4'b1000, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0, 2'b00, 1'b0, 2, 0, 0));
        tbl.push_back(mkVec(4'b0111, 32'h0000FFFF, 32'h00000000, 32'hFFFF0000, 1'b0, 1'b0, 2'b00, 1'b0, 2, 0, 0));
        tbl.push_back(mkVec(4'b1011, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 2'b00, 1'b0, 2, 0, 0));
        tbl.push_back(mkVec(4'b1001, 32'h80000001, 32'h00000000, 32'h00000002, 1'b0, 1'b0, 2'b01, 1'b0, 2, 0, 0));
        tbl.push_back(mkVec(4'b0001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 2'b00, 1'b0, 2, 0, 0));
        tbl.push_back(mkVec(4'b0000, 32'h11111111, 32'h11111111, 32'h00000000, 1'b0, 1'b0, 2'b00, 1'b0, 1, 0, 0));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].op, tbl[i].a, tbl[i].b, acc);
            checks++;
            if (acc !== 1'b1) begin
                failures++;
                $display("[TB] FAIL alu_accept[%0d]: cmd_ready=%b required 1", i, acc);
            end
            sbq.push_back(tbl[i]);
            waitResponse(lat);
            e = sbq.pop_front();
            checks++;
            if (lat !== e.lat) begin
                failures++;
                $display("[TB] FAIL alu_latency[%0d] op=%b: got %0d cycles, required %0d", i, e.op, lat, e.lat);
            end
            checks++;
            if ({rsp_result, rsp_overflow, rsp_equal, rsp_carry, rsp_err} !== {e.res, e.ovf, e.eq, e.carry, e.err}) begin
                failures++;
                $display("[TB] FAIL alu_result[%0d] op=%b: got res=%h ovf=%b eq=%b c=%b err=%b, required res=%h ovf=%b eq=%b c=%b err=%b",
                         i, e.op, rsp_result, rsp_overflow, rsp_equal, rsp_carry, rsp_err,
                         e.res, e.ovf, e.eq, e.carry, e.err);
            end
            completeHandshake();
            checks++;
            if (op_count !== 16'(expCount)) begin
                failures++;
                $display("[TB] FAIL alu_op_count[%0d]: got %0d, required %0d", i, op_count, expCount);
            end
        end
    endtask

    task automatic test_shln();
        vec_t tbl[$];
        vec_t e;
        int   lat;
        bit   acc;
        tbl.push_back(mkVec(4'b1100, 32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 2'b00, 1'b0, 5, 4, 0));
        tbl.push_back(mkVec(4'b1100, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 2'b00, 1'b0, 2, 0, 1));
        tbl.push_back(mkVec(4'b1100, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 2'b00, 1'b0, 2, 0, 1));
        tbl.push_back(mkVec(4'b1100, 32'h80000003, 32'h00000021, 32'h00000006, 1'b0, 1'b0, 2'b00, 1'b0, 2, 1, 0));
        tbl.push_back(mkVec(4'b1100, 32'hFFFFFFFF, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 2'b00, 1'b0, 32, 31, 0));
        foreach (tbl[i]) begin
            shl1Cycles = 0;
            movCycles  = 0;
            applyStimulus(tbl[i].op, tbl[i].a, tbl[i].b, acc);
            sbq.push_back(tbl[i]);
            waitResponse(lat);
            e = sbq.pop_front();
            checks++;
            if (lat !== e.lat) begin
                failures++;
                $display("[TB] FAIL shln_latency[%0d]: got %0d cycles, required %0d", i, lat, e.lat);
            end
            checks++;
            if ({rsp_result, rsp_overflow, rsp_equal, rsp_carry, rsp_err} !== {e.res, e.ovf, e.eq, e.carry, e.err}) begin
                failures++;
                $display("[TB] FAIL shln_result[%0d]: got res=%h ovf=%b eq=%b c=%b err=%b, required res=%h flags 0",
                         i, rsp_result, rsp_overflow, rsp_equal, rsp_carry, rsp_err, e.res);
            end
            checks++;
            if (shl1Cycles !== e.shl || movCycles !== e.mov) begin
                failures++;
                $display("[TB] FAIL shln_passes[%0d]: got shl1=%0d mov=%0d, required shl1=%0d mov=%0d",
                         i, shl1Cycles, movCycles, e.shl, e.mov);
            end
            completeHandshake();
            checks++;
            if (op_count !== 16'(expCount)) begin
                failures++;
                $display("[TB] FAIL shln_op_count[%0d]: got %0d, required %0d", i, op_count, expCount);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] ops [3];
        vec_t e;
        int   lat;
        bit   acc;
        ops[0] = 4'b0011;
        ops[1] = 4'b1010;
        ops[2] = 4'b1111;
        foreach (ops[i]) begin
            opselNonZero = 0;
            applyStimulus(ops[i], 32'h00000005, 32'h00000005, acc);
            sbq.push_back(mkVec(ops[i], 32'h5, 32'h5, 32'h0, 1'b0, 1'b0, 2'b00, 1'b1, 1, 0, 0));
            waitResponse(lat);
            e = sbq.pop_front();
            checks++;
            if (lat !== e.lat || {rsp_result, rsp_overflow, rsp_equal, rsp_carry, rsp_err} !== {e.res, e.ovf, e.eq, e.carry, e.err}) begin
                failures++;
                $display("[TB] FAIL illegal[%0d] op=%b: got lat=%0d res=%h err=%b, required lat=1 res=0 err=1",
                         i, ops[i], lat, rsp_result, rsp_err);
            end
            completeHandshake();
            checks++;
            if (opselNonZero !== 0 || op_count !== 16'(expCount)) begin
                failures++;
                $display("[TB] FAIL illegal_opsel[%0d]: got %0d nonzero opsel cycles count=%0d, required 0 and %0d",
                         i, opselNonZero, op_count, expCount);
            end
        end
    endtask

    task automatic test_backpressure();
        vec_t        e;
        int          lat;
        bit          acc;
        logic [36:0] snap;
        bit          leaked;
        applyStimulus(4'b0001, 32'h00000010, 32'h00000020, acc);
        sbq.push_back(mkVec(4'b0001, 32'h10, 32'h20, 32'h00000030, 1'b0, 1'b0, 2'b00, 1'b0, 2, 0, 0));
        waitResponse(lat);
        e = sbq.pop_front();
        checks++;
        if (lat !== e.lat || rsp_result !== e.res) begin
            failures++;
            $display("[TB] FAIL bp_response: got lat=%0d res=%h, required lat=%0d res=%h", lat, rsp_result, e.lat, e.res);
        end
        snap = {rsp_result, rsp_overflow, rsp_equal, rsp_carry, rsp_err};
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1;
            cmd_op    = 4'b0000;
            cmd_a     = 32'hA5A5A5A5;
            cmd_b     = 32'h5A5A5A5A;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
                {rsp_result, rsp_overflow, rsp_equal, rsp_carry, rsp_err} !== snap) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b ready=%b res=%h, required 1/0 res=%h",
                         k, rsp_valid, cmd_ready, rsp_result, snap[36:5]);
            end
        end
        completeHandshake();
        checks++;
        if (op_count !== 16'(expCount)) begin
            failures++;
            $display("[TB] FAIL bp_op_count: got %0d, required %0d", op_count, expCount);
        end
        // rsp_ready held high while idle must not count extra responses.
        rsp_ready = 1'b1;
        leaked = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || busy) leaked = 1'b1;
        end
        rsp_ready = 1'b0;
        checks++;
        if (leaked !== 1'b0 || op_count !== 16'(expCount)) begin
            failures++;
            $display("[TB] FAIL bp_no_extra: got leaked=%b count=%0d, required 0 and %0d", leaked, op_count, expCount);
        end
    endtask

    task automatic test_reset_mid_shln();
        vec_t e;
        int   lat;
        bit   acc;
        bit   leaked;
        applyStimulus(4'b1100, 32'h00000001, 32'h00000005, acc);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (aluOpsel !== 4'b1001 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL shln_in_flight: got opsel=%b busy=%b, required 1001/1", aluOpsel, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, busy, aluOpsel, aluOperandA, aluOperandB, rsp_result,
             rsp_overflow, rsp_equal, rsp_carry, rsp_err, op_count} !== '0) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs: got ready=%b valid=%b busy=%b opsel=%b opA=%h count=%0d, required all zero",
                     cmd_ready, rsp_valid, busy, aluOpsel, aluOperandA, op_count);
        end
        expCount = 0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_reset_release: cmd_ready=%b required 1", cmd_ready);
        end
        leaked = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) leaked = 1'b1;
        end
        checks++;
        if (leaked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_no_response: rsp_valid seen=%b required 0", leaked);
        end
        applyStimulus(4'b0001, 32'h00000002, 32'h00000003, acc);
        sbq.push_back(mkVec(4'b0001, 32'h2, 32'h3, 32'h00000005, 1'b0, 1'b0, 2'b00, 1'b0, 2, 0, 0));
        waitResponse(lat);
        e = sbq.pop_front();
        checks++;
        if (lat !== e.lat || {rsp_result, rsp_overflow, rsp_equal, rsp_carry, rsp_err} !== {e.res, e.ovf, e.eq, e.carry, e.err}) begin
            failures++;
            $display("[TB] FAIL post_reset_add: got lat=%0d res=%h, required lat=%0d res=%h", lat, rsp_result, e.lat, e.res);
        end
        completeHandshake();
        checks++;
        if (op_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL post_reset_count: got %0d, required 1", op_count);
        end
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 4'b0000;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_alu_ops();
        test_shln();
        test_illegal();
        test_backpressure();
        test_reset_mid_shln();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
